// File: rtl/imem_pkg.sv
// Shared constants and the pipeline-stage record for the instruction memory.
package imem_pkg;

  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DEPTH  = 1024;
  localparam int LATENCY_MAX = 4;

  localparam logic [IMEM_DATA_W-1:0] IMEM_ERR_INST = 32'h0000_0000;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [IMEM_DATA_W-1:0] inst;
  } imem_stage_t;

endpackage

// File: rtl/imem_rd_pipe.sv
// Read-response delay line: the valid, err and inst fields of each stage move together.
// Stage 0 captures the accepted request; the output is stage LATENCY.
module imem_rd_pipe
  import imem_pkg::*;
#(
  parameter int DATA_W  = IMEM_DATA_W,
  parameter int LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_vld,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_inst,
  output logic              o_vld,
  output logic              o_err,
  output logic [DATA_W-1:0] o_inst
);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] inst;
  } stage_dat_t;

  logic       [LATENCY:0] r_vld_pipe;
  stage_dat_t [LATENCY:0] r_dat_pipe;
  stage_dat_t             w_dat_in;

  assign w_dat_in = '{err: i_err, inst: i_inst};

  // Flush kills every stage, including the request being captured this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe <= i_flush ? '0 : {r_vld_pipe[LATENCY-1:0], i_vld};
      r_dat_pipe <= {r_dat_pipe[LATENCY-1:0], w_dat_in};
    end
  end

  assign o_vld  = r_vld_pipe[LATENCY];
  assign o_err  = r_dat_pipe[LATENCY].err;
  assign o_inst = r_dat_pipe[LATENCY].inst;

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction memory with valid/ready fetch port, loader write port and error reporting.
// Optional IMEM_PERF_CNT_EN adds saturating fetch/error counters.
module inst_fetch_mem
  import imem_pkg::*;
#(
  parameter int              DATA_W    = IMEM_DATA_W,
  parameter int              ADDR_W    = IMEM_ADDR_W,
  parameter int              DEPTH     = IMEM_DEPTH,
  parameter int              LATENCY   = 1,
  parameter int              BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] ERR_INST = DATA_W'(IMEM_ERR_INST)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ADDR_W-1:0]        i_req_addr,
  input  logic                     i_flush,
  output logic                     o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_inst,
  output logic                     o_rsp_err,
`ifdef IMEM_PERF_CNT_EN
  output logic [31:0]              o_fetch_cnt,
  output logic [15:0]              o_err_cnt,
`endif
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
  input  logic [DATA_W-1:0]        i_ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic [ADDR_W-1:0] w_word;
  logic [ADDR_W-1:0] w_hi;
  logic              w_mis;
  logic              w_oor;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_inst;

  // Loader owns the array port whenever it strobes.
  assign o_req_ready = !i_ld_en;
  assign w_accept    = i_req_valid && o_req_ready;

  generate
    if (BYTE_ADDR != 0) begin : g_byte_addr
      assign w_word = i_req_addr >> 2;
      assign w_mis  = |i_req_addr[1:0];
    end else begin : g_word_addr
      assign w_word = i_req_addr;
      assign w_mis  = 1'b0;
    end
  endgenerate

  assign w_hi   = w_word >> IDX_W;
  assign w_oor  = |w_hi;
  assign w_err  = w_oor || w_mis;
  assign w_idx  = w_word[IDX_W-1:0];
  assign w_inst = w_err ? ERR_INST : r_mem[w_idx];

  // Contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_ld_en) r_mem[i_ld_addr] <= i_ld_data;
  end

  imem_rd_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_vld   (w_accept),
    .i_err   (w_err),
    .i_inst  (w_inst),
    .o_vld   (o_rsp_valid),
    .o_err   (o_rsp_err),
    .o_inst  (o_rsp_inst)
  );

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_err_cnt;

  // Flushed fetches still count as fetched; only delivered error responses count as errors.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_accept && (r_fetch_cnt != '1))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (o_rsp_valid && o_rsp_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_err_cnt   = r_err_cnt;
`endif

endmodule
